// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: tnew/tuse encoding, mult/div latency defaults
// and the one-cycle tnew decay used by the M-stage shadow.
package pipe_pkg;

  // Cycles until a value is needed (tuse) or produced (tnew).
  typedef logic [1:0] tnew_t;

  localparam tnew_t TNEW_ALU  = 2'd1;
  localparam tnew_t TNEW_LOAD = 2'd2;
  localparam tnew_t TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // A producer moving one stage forward is one cycle closer to its result.
  function automatic tnew_t tnew_decay(tnew_t t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D/E-stage hazard inputs and stall outputs of the stall controller.
// master: pipeline side driving stage info; slave: the controller.
interface hazard_stall_ctrl_if;
  import pipe_pkg::*;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  tnew_t      tuse_rs_D;
  tnew_t      tuse_rt_D;
  logic       md_use_D;
  logic [4:0] WA_E;
  logic       RegWrite_E;
  tnew_t      tnew_E;
  logic       md_start_E;
  logic       md_is_div_E;
  logic       pc_en;
  logic       d_en;
  logic       flush_E;
  logic       md_busy;
  logic       md_err;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    output WA_E, RegWrite_E, tnew_E, md_start_E, md_is_div_E,
    input  pc_en, d_en, flush_E, md_busy, md_err
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    input  WA_E, RegWrite_E, tnew_E, md_start_E, md_is_div_E,
    output pc_en, d_en, flush_E, md_busy, md_err
  );

endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div busy countdown. Loads on an issue while idle, counts down to zero,
// and flags (sticky) any issue that arrives while still busy.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy,
  output logic md_err
);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             md_err_q, md_err_d;

  // Reload on an idle issue; otherwise drain toward zero and never wrap.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    md_err_d   = md_err_q;
    if (md_start && busy_cnt_q == '0) begin
      busy_cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      if (md_start) md_err_d = 1'b1;
      if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  // Counter and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q <= '0;
      md_err_q   <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      md_err_q   <= md_err_d;
    end
  end

  assign md_busy = (busy_cnt_q != '0);
  assign md_err  = md_err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Tnew/Tuse data hazard check against E and a private M-stage shadow,
// plus mult/div busy interlock.
// Optional: HAZARD_STALL_STATS_EN adds stall_cnt / md_stall_cnt counters.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_stall_ctrl_if.slave    bus
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           md_stall_cnt
`endif
);

  // Shadow of the M-stage writer; M never stalls so it just follows E.
  logic [4:0] wa_m_s_q, wa_m_s_d;
  logic       regwrite_m_s_q, regwrite_m_s_d;
  tnew_t      tnew_m_s_q, tnew_m_s_d;

  logic md_busy;
  logic rs_stall, rt_stall, md_stall, stall;

  // Next shadow state: E moves into M with one cycle of tnew elapsed.
  always_comb begin
    wa_m_s_d       = bus.WA_E;
    regwrite_m_s_d = bus.RegWrite_E;
    tnew_m_s_d     = tnew_decay(bus.tnew_E);
  end

  // Shadow M registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wa_m_s_q       <= '0;
      regwrite_m_s_q <= 1'b0;
      tnew_m_s_q     <= '0;
    end else begin
      wa_m_s_q       <= wa_m_s_d;
      regwrite_m_s_q <= regwrite_m_s_d;
      tnew_m_s_q     <= tnew_m_s_d;
    end
  end

  // Stall when a pending producer's result arrives later than the consumer
  // needs it; $0 is hardwired and never a dependency.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    if (bus.rs_D != 5'd0) begin
      if (bus.RegWrite_E && bus.WA_E == bus.rs_D && bus.tnew_E > bus.tuse_rs_D)
        rs_stall = 1'b1;
      if (regwrite_m_s_q && wa_m_s_q == bus.rs_D && tnew_m_s_q > bus.tuse_rs_D)
        rs_stall = 1'b1;
    end
    if (bus.rt_D != 5'd0) begin
      if (bus.RegWrite_E && bus.WA_E == bus.rt_D && bus.tnew_E > bus.tuse_rt_D)
        rt_stall = 1'b1;
      if (regwrite_m_s_q && wa_m_s_q == bus.rt_D && tnew_m_s_q > bus.tuse_rt_D)
        rt_stall = 1'b1;
    end
    // An issue in E this cycle makes the unit busy before D could use it.
    md_stall = bus.md_use_D && (md_busy || bus.md_start_E);
    stall    = rs_stall | rt_stall | md_stall;
  end

  assign bus.pc_en   = ~stall;
  assign bus.d_en    = ~stall;
  assign bus.flush_E = stall;
  assign bus.md_busy = md_busy;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk       (clk),
    .reset     (reset),
    .md_start  (bus.md_start_E),
    .md_is_div (bus.md_is_div_E),
    .md_busy   (md_busy),
    .md_err    (bus.md_err)
  );

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  // Free-running event counters; wrap naturally at 32 bits.
  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, md_stall};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: hazard vector table, hand-written multi-cycle
// sequences, and randomized traffic against a cycle-count reference model.
module tb_hazard_stall_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: the most recent writer that left E, how many cycles
  // its result still needs, and cycles remaining on the mult/div unit.
  int m_wa, m_rw, m_tnew, m_busy;
  bit m_err;

  function automatic int wait_cycles(int r, int tuse);
    int w = 0;
    if (r == 0) return 0;
    if (bus.RegWrite_E && int'(bus.WA_E) == r && int'(bus.tnew_E) - tuse > w)
      w = int'(bus.tnew_E) - tuse;
    if (m_rw != 0 && m_wa == r && m_tnew - tuse > w)
      w = m_tnew - tuse;
    return w;
  endfunction

  function automatic bit model_stall();
    bit s;
    s = (wait_cycles(int'(bus.rs_D), int'(bus.tuse_rs_D)) > 0) ||
        (wait_cycles(int'(bus.rt_D), int'(bus.tuse_rt_D)) > 0);
    if (bus.md_use_D && (m_busy > 0 || bus.md_start_E)) s = 1'b1;
    return s;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_wa = 0; m_rw = 0; m_tnew = 0; m_busy = 0; m_err = 0;
    end else begin
      m_wa   = int'(bus.WA_E);
      m_rw   = int'(bus.RegWrite_E);
      m_tnew = (bus.tnew_E == 2'd0) ? 0 : int'(bus.tnew_E) - 1;
      if (bus.md_start_E && m_busy == 0) m_busy = bus.md_is_div_E ? 10 : 5;
      else begin
        if (bus.md_start_E) m_err = 1'b1;
        if (m_busy > 0) m_busy--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {29'd0, bus.pc_en, bus.d_en, bus.flush_E};
  endfunction

  function automatic logic [31:0] want(bit s);
    return s ? 32'b001 : 32'b110;
  endfunction

  task automatic quiet();
    bus.rs_D = 5'd0; bus.rt_D = 5'd0;
    bus.tuse_rs_D = TUSE_NONE; bus.tuse_rt_D = TUSE_NONE;
    bus.md_use_D = 1'b0;
    bus.WA_E = 5'd0; bus.RegWrite_E = 1'b0; bus.tnew_E = 2'd0;
    bus.md_start_E = 1'b0; bus.md_is_div_E = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    string      nm;
    logic [4:0] p_wa; logic p_rw; tnew_t p_tnew;   // writer in E one cycle earlier
    logic [4:0] wa;   logic rw;   tnew_t tnew;     // writer in E now
    logic [4:0] rs;   tnew_t tu_rs;
    logic [4:0] rt;   tnew_t tu_rt;
    bit         stall;
  } vec_t;

  vec_t vt[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt.push_back('{"load_use",    0,0,0, 8,1,2, 8,1, 0,3, 1});
    vt.push_back('{"load_use_rel",8,1,2, 0,0,0, 8,1, 0,3, 0});
    vt.push_back('{"alu_beq",     0,0,0, 9,1,1, 9,0, 0,3, 1});
    vt.push_back('{"alu_beq_rel", 9,1,1, 0,0,0, 9,0, 0,3, 0});
    vt.push_back('{"alu_tuse1",   0,0,0, 9,1,1, 9,1, 0,3, 0});
    vt.push_back('{"zero_reg",    0,0,0, 0,1,2, 0,0, 0,3, 0});
    vt.push_back('{"tuse_none",   0,0,0, 8,1,2, 0,3, 8,3, 0});
    vt.push_back('{"rt_load_e",   0,0,0, 5,1,2, 0,3, 5,1, 1});
    vt.push_back('{"rt_load_m",   5,1,2, 0,0,0, 0,3, 5,0, 1});
    vt.push_back('{"e_no_write",  0,0,0, 8,0,2, 8,0, 0,3, 0});
    vt.push_back('{"m_no_write",  8,0,2, 0,0,0, 8,0, 0,3, 0});
    vt.push_back('{"m_other_reg", 7,1,2, 0,0,0, 8,0, 8,0, 0});

    do_reset();
    do_reset();
    chk("reset_outs", outs(), 32'b110);
    chk("reset_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("reset_err",  {31'd0, bus.md_err}, 32'd0);

    // Hazard vector table.
    foreach (vt[i]) begin
      quiet();
      bus.WA_E = vt[i].p_wa; bus.RegWrite_E = vt[i].p_rw; bus.tnew_E = vt[i].p_tnew;
      step();
      bus.WA_E = vt[i].wa; bus.RegWrite_E = vt[i].rw; bus.tnew_E = vt[i].tnew;
      bus.rs_D = vt[i].rs; bus.tuse_rs_D = vt[i].tu_rs;
      bus.rt_D = vt[i].rt; bus.tuse_rt_D = vt[i].tu_rt;
      #1;
      chk(vt[i].nm, outs(), want(vt[i].stall));
      step();
    end

    // Div: busy exactly 10 cycles, mflo in D stalls throughout.
    do_reset();
    bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1; bus.md_use_D = 1'b1;
    #1;
    chk("div_issue_stall", outs(), want(1));
    step();
    bus.md_start_E = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("div_busy", {31'd0, bus.md_busy}, 32'd1);
      chk("div_stall", outs(), want(1));
      step();
    end
    #1;
    chk("div_done_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("div_release", outs(), want(0));

    // Mult then reset mid-count, with a load in E at the reset edge.
    do_reset();
    bus.md_start_E = 1'b1;
    step();
    bus.md_start_E = 1'b0;
    step();
    step();
    bus.WA_E = 5'd8; bus.RegWrite_E = 1'b1; bus.tnew_E = 2'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    quiet();
    bus.rs_D = 5'd8; bus.tuse_rs_D = 2'd0; bus.md_use_D = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rst_shadow_stall", outs(), want(0));

    // Issue while busy: sticky error, no reload.
    do_reset();
    bus.md_start_E = 1'b1;
    step();
    bus.md_start_E = 1'b0;
    step();
    step();
    bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1;
    step();
    bus.md_start_E = 1'b0;
    #1;
    chk("err_set", {31'd0, bus.md_err}, 32'd1);
    chk("err_busy2", {31'd0, bus.md_busy}, 32'd1);
    step();
    chk("err_busy1", {31'd0, bus.md_busy}, 32'd1);
    step();
    chk("err_busy0", {31'd0, bus.md_busy}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("err_sticky", {31'd0, bus.md_err}, 32'd1);
    do_reset();
    #1;
    chk("err_cleared", {31'd0, bus.md_err}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.rs_D = 5'($urandom_range(0, 6));
      bus.rt_D = 5'($urandom_range(0, 6));
      bus.tuse_rs_D = 2'($urandom_range(0, 3));
      bus.tuse_rt_D = 2'($urandom_range(0, 3));
      bus.md_use_D = 1'($urandom_range(0, 1));
      bus.WA_E = 5'($urandom_range(0, 6));
      bus.RegWrite_E = 1'($urandom_range(0, 1));
      bus.tnew_E = 2'($urandom_range(0, 2));
      bus.md_start_E = ($urandom_range(0, 7) == 0);
      bus.md_is_div_E = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_stall", outs(), want(model_stall()));
      chk("rnd_busy", {31'd0, bus.md_busy}, {31'd0, m_busy > 0});
      chk("rnd_err", {31'd0, bus.md_err}, {31'd0, m_err});
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
